// File: rtl/gf180mcu_fd_sc_mcu7t5v0__seq_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__seq_pkg: shared state enum, limits and thermometer decode for segment sequencers
package gf180mcu_fd_sc_mcu7t5v0__seq_pkg;
  localparam int MAX_NSEG = 16;
  typedef enum logic [1:0] {OFF, UP, ON, DOWN} seq_st_e;
  function automatic logic [MAX_NSEG-1:0] therm(input logic [4:0] n);
    logic [MAX_NSEG-1:0] t;
    for (int i = 0; i < MAX_NSEG; i++) t[i] = 5'(i) < n;
    return t;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_seq_if.sv
// gf180mcu_fd_sc_mcu7t5v0__buf_seq_if: enable request and segment-enable bundle between pad logic and sequencer
interface gf180mcu_fd_sc_mcu7t5v0__buf_seq_if #(parameter int NSEG = 8, parameter int GAPW = 4);
  logic en;
  logic [GAPW-1:0] gap;
  logic [NSEG-1:0] segen;
  logic ready;
  logic idle;
  modport master(output en, gap, input segen, ready, idle);
  modport slave(input en, gap, output segen, ready, idle);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__seq_tmr.sv
// gf180mcu_fd_sc_mcu7t5v0__seq_tmr: loadable down-counter with zero flag for step spacing
module gf180mcu_fd_sc_mcu7t5v0__seq_tmr #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic         z
);
  logic [W-1:0] q;
  // reload wins over counting; counting saturates at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (ld) q <= d;
    else if (dec && q != '0) q <= q - W'(1);
  assign z = q == '0;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_seq.sv
// gf180mcu_fd_sc_mcu7t5v0__buf_seq: staged on/off sequencer for a segmented high-drive buffer bank
module gf180mcu_fd_sc_mcu7t5v0__buf_seq
  import gf180mcu_fd_sc_mcu7t5v0__seq_pkg::*;
#(parameter int NSEG = 8, parameter int GAPW = 4) (
  input logic clk,
  input logic rst,
  gf180mcu_fd_sc_mcu7t5v0__buf_seq_if.slave bus,
  inout wire vdd,
  inout wire vss
);
  localparam int CW = $clog2(NSEG + 1);
  seq_st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NSEG-1:0] segen;
  logic ready, idle, z, ld, dec, up, dn, mv, pwr_unused;
  assign pwr_unused = vdd ^ vss;
  gf180mcu_fd_sc_mcu7t5v0__seq_tmr #(.W(GAPW)) u_tmr (
    .clk(clk), .rst(rst), .ld(ld), .dec(dec), .d(bus.gap), .z(z)
  );
  // every count change is one step toward EN and reloads the spacing timer
  always_comb begin
    up = st == UP;
    dn = st == DOWN;
    mv = (up && bus.en) || (dn && !bus.en);
    ld = (st == OFF && bus.en) || (st == ON && !bus.en) || ((up || dn) && (!mv || z));
    dec = mv && !z;
    cnt_n = ld ? (bus.en ? cnt + CW'(1) : cnt - CW'(1)) : cnt;
    st_n = !ld ? st : cnt_n == CW'(NSEG) ? ON : cnt_n == '0 ? OFF : bus.en ? UP : DOWN;
  end
  // state, count and all outputs registered together so SEGEN tracks cnt exactly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= OFF;
      cnt <= '0;
      segen <= '0;
      ready <= 1'b0;
      idle <= 1'b1;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      segen <= NSEG'(therm(5'(cnt_n)));
      ready <= st_n == ON;
      idle <= st_n == OFF;
    end
  assign bus.segen = segen;
  assign bus.ready = ready;
  assign bus.idle = idle;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_seq.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__buf_seq: directed checks of ramp, release, reversal, gap change and reset
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  wire vdd = 1'b1;
  wire vss = 1'b0;
  gf180mcu_fd_sc_mcu7t5v0__buf_seq_if #(.NSEG(8), .GAPW(4)) bus ();
  gf180mcu_fd_sc_mcu7t5v0__buf_seq #(.NSEG(8), .GAPW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .vdd(vdd), .vss(vss)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] th(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction
  initial begin
    bus.en = 1'b1;
    bus.gap = 4'd0;
    step(2);
    chk("rst_segen", 32'(bus.segen), 32'h00);
    chk("rst_idle", 32'(bus.idle), 32'h1);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    rst = 1'b0;
    step(1);
    chk("first_edge", 32'(bus.segen), 32'h01);
    chk("first_idle", 32'(bus.idle), 32'h0);
    bus.en = 1'b0;
    step(1);
    chk("up_rev_off", 32'(bus.segen), 32'h00);
    chk("up_rev_idle", 32'(bus.idle), 32'h1);
    bus.gap = 4'd2;
    bus.en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      chk($sformatf("ramp_seg%0d", k), 32'(bus.segen), 32'(th((1 + (k - 1) / 3) > 8 ? 8 : 1 + (k - 1) / 3)));
      chk($sformatf("ramp_rdy%0d", k), 32'(bus.ready), 32'(k >= 22));
      chk($sformatf("ramp_idle%0d", k), 32'(bus.idle), 32'h0);
    end
    bus.gap = 4'd0;
    bus.en = 1'b0;
    step(1);
    chk("on_drop", 32'(bus.segen), 32'h7F);
    chk("on_drop_rdy", 32'(bus.ready), 32'h0);
    bus.en = 1'b1;
    step(1);
    chk("dn_rev_on", 32'(bus.segen), 32'hFF);
    chk("dn_rev_rdy", 32'(bus.ready), 32'h1);
    bus.en = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk($sformatf("down_seg%0d", k), 32'(bus.segen), 32'(th(k > 8 ? 0 : 8 - k)));
      chk($sformatf("down_idle%0d", k), 32'(bus.idle), 32'(k >= 8));
      chk($sformatf("down_rdy%0d", k), 32'(bus.ready), 32'h0);
    end
    bus.gap = 4'd3;
    bus.en = 1'b1;
    step(12);
    chk("rev_pre", 32'(bus.segen), 32'h07);
    step(1);
    chk("rev_at0f", 32'(bus.segen), 32'h0F);
    bus.en = 1'b0;
    step(1);
    chk("rev_dn", 32'(bus.segen), 32'h07);
    step(1);
    chk("rev_hold", 32'(bus.segen), 32'h07);
    bus.en = 1'b1;
    step(1);
    chk("rev_up", 32'(bus.segen), 32'h0F);
    bus.gap = 4'd0;
    bus.en = 1'b0;
    step(4);
    chk("rev_off", 32'(bus.segen), 32'h00);
    chk("rev_idle", 32'(bus.idle), 32'h1);
    bus.gap = 4'd1;
    bus.en = 1'b1;
    step(1);
    chk("gap_e1", 32'(bus.segen), 32'h01);
    bus.gap = 4'd5;
    step(1);
    chk("gap_e2", 32'(bus.segen), 32'h01);
    step(1);
    chk("gap_e3", 32'(bus.segen), 32'h03);
    step(5);
    chk("gap_e8", 32'(bus.segen), 32'h03);
    step(1);
    chk("gap_e9", 32'(bus.segen), 32'h07);
    step(5);
    chk("gap_e14", 32'(bus.segen), 32'h07);
    step(1);
    chk("gap_e15", 32'(bus.segen), 32'h0F);
    step(6);
    chk("gap_e21", 32'(bus.segen), 32'h1F);
    rst = 1'b1;
    #1;
    chk("arst_segen", 32'(bus.segen), 32'h00);
    chk("arst_idle", 32'(bus.idle), 32'h1);
    chk("arst_ready", 32'(bus.ready), 32'h0);
    bus.gap = 4'd0;
    step(1);
    rst = 1'b0;
    step(1);
    chk("fresh1", 32'(bus.segen), 32'h01);
    step(1);
    chk("fresh2", 32'(bus.segen), 32'h03);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__buf_seq.md
# gf180mcu_fd_sc_mcu7t5v0__buf_seq

Staged enable sequencer for a segmented high-drive output buffer: a bank of NSEG parallel 20x buffer slices, each gated by one SEGEN bit. On an enable request it turns the slices on one at a time, with programmable spacing, to bound supply di/dt. On release it turns them off in reverse order. It sits between the chip-level pad/clock-tree enable logic and the segmented driver bank.

## Interface
- NSEG, 8: number of buffer segments, range 2..16.
- GAPW, 4: width of the GAP spacing input.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  level request: 1 = drive fully on, 0 = fully off.
- GAP  input  GAPW  extra idle cycles between consecutive segment steps.
- SEGEN  output  NSEG  per-segment enable, thermometer code from bit 0 upward.
- READY  output  1  all segments on and stable.
- IDLE  output  1  all segments off and stable.
- VDD, VSS  inout  1  supply pins, no logical function.

## Operation
- State: cnt, range 0..NSEG, giving the number of enabled segments. SEGEN[i] = (i < cnt), registered.
- Step timer: tmr, GAPW bits.
- FSM states are OFF, UP, ON and DOWN.
- OFF (cnt=0):
  - EN=1 → UP, cnt←1, tmr←GAP.
- UP:
  - EN=0 → DOWN, cnt←cnt−1, tmr←GAP.
  - Otherwise, if tmr≠0, tmr−1.
  - Otherwise cnt←cnt+1 and tmr←GAP. If the new cnt = NSEG → ON.
- ON (cnt=NSEG):
  - EN=0 → DOWN, cnt←NSEG−1, tmr←GAP.
- DOWN:
  - EN=1 → UP, cnt←cnt+1, tmr←GAP.
  - Otherwise, if tmr≠0, tmr−1.
  - Otherwise cnt←cnt−1 and tmr←GAP. If the new cnt = 0 → OFF.
- A reversal step that reaches a terminal count goes directly to that terminal state:
  - DOWN reversal reaching cnt=NSEG → ON.
  - UP reversal reaching cnt=0 → OFF.
- cnt never leaves 0..NSEG. No segment is ever skipped. At most one SEGEN bit changes per clock.
- GAP is sampled only when tmr is reloaded. A change mid-interval takes effect at the next step.
- READY = (state==ON). IDLE = (state==OFF). Both are registered and never high together.

## Timing
- Reset (async assert, sync release by the user): state=OFF, cnt=0, tmr=0, SEGEN=0, READY=0, IDLE=1.
- Reset mid-ramp clears all segments immediately, without sequencing.
- Latency: first SEGEN bit rises on the first edge that samples EN=1 in OFF.
- Full ramp: READY rises 1+(NSEG−1)(GAP+1) cycles after EN is first sampled high, with GAP constant.
- Ramp-down is symmetric. IDLE rises 1+(NSEG−1)(GAP+1) cycles after EN is first sampled low in ON.
- Reversal: the first step in the new direction occurs on the same edge that samples the EN change.
- GAP=0 gives one segment per cycle.
- GAP all-ones gives 2^GAPW cycles per step.

## Structure
- Shared package gf180mcu_fd_sc_mcu7t5v0__seq_pkg holds:
  - the state enum (OFF/UP/ON/DOWN);
  - constant for max NSEG (16);
  - thermometer-decode function.
- One sub-module, gf180mcu_fd_sc_mcu7t5v0__seq_tmr: a loadable GAPW-bit down-counter with zero flag, reused by other sequencers.
- FSM, cnt and output registers stay in the top module.
- Power pins pass through unused.

## Test plan
- Reset with EN=1 held → SEGEN=0, IDLE=1, READY=0 while RST=1. After release, SEGEN=0x01 on the first edge.
- NSEG=8, GAP=2, EN 0→1:
  - SEGEN steps 0x01, 0x03, … 0xFF, one step every 3 cycles.
  - READY=1 at cycle 22 with SEGEN=0xFF.
  - IDLE falls with the first step.
- In ON, drop EN, GAP=0 → SEGEN 0x7F, 0x3F, … 0x00 on consecutive edges. IDLE=1 on edge 8.
- Reversal: GAP=3, drop EN when SEGEN=0x0F:
  - next edge gives 0x07;
  - raise EN two cycles later, next edge gives 0x0F;
  - no bit ever jumps by more than one.
- Change GAP from 1 to 5 mid-interval → the current interval keeps 2 cycles, following intervals take 6.
- Assert RST when SEGEN=0x1F during UP → SEGEN=0x00 asynchronously, IDLE=1, then a fresh ramp from 0x01.
